// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the I/D cache memory-port arbiter: FSM encoding,
// requester IDs and default block geometry.
package cache_mem_arbiter_pkg;

    localparam int unsigned DefaultAddrW = 28;
    localparam int unsigned DefaultDataW = 128;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusyI = 2'd1,
        StBusyD = 2'd2,
        StDone  = 2'd3
    } arb_state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one block-level memory port between the I-cache
// refill path and the D-cache refill/write-back path.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DefaultAddrW,
    parameter int unsigned DATA_W = DefaultDataW
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;

    logic i_pend, d_pend;
    logic grant_i, grant_d;

    assign i_pend = i_read;
    assign d_pend = d_read | d_write;

    // I wins when alone, or when both pend and D was served last.
    assign grant_i = i_pend & (~d_pend | (last_grant_q == REQ_D));
    assign grant_d = d_pend & ~grant_i;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (grant_i) begin
                    state_d     = StBusyI;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = i_addr;
                end else if (grant_d) begin
                    // A simultaneous read+write is a protocol error; the write wins.
                    state_d     = StBusyD;
                    mem_read_d  = ~d_write;
                    mem_write_d = d_write;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end
            end

            StBusyI: begin
                if (mem_ready) begin
                    state_d      = StDone;
                    i_rdata_d    = mem_rdata;
                    i_ready_d    = 1'b1;
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    last_grant_d = REQ_I;
                end
            end

            StBusyD: begin
                if (mem_ready) begin
                    state_d      = StDone;
                    d_rdata_d    = mem_rdata;
                    d_ready_d    = 1'b1;
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    last_grant_d = REQ_D;
                end
            end

            // One dead cycle lets the served cache drop its request.
            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= REQ_D;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
        end
    end

    assign i_ready   = i_ready_q;
    assign i_rdata   = i_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_rdata   = d_rdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
